// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential ALU.
//   alu_op_t  - 4-bit opcode set (0x0..0xC defined, 0xD..0xF yield zero)
//   state_t   - control FSM states
//   BCD_CORR  - decimal correction added to a digit sum above 9
//   is_shift  - true for the opcodes that shift/rotate shamt positions
package alu_pkg;

    typedef enum logic [3:0] {
        OP_INC  = 4'h0,
        OP_DEC  = 4'h1,
        OP_ADC  = 4'h2,
        OP_SBC  = 4'h3,
        OP_ROR  = 4'h4,
        OP_ASL  = 4'h5,
        OP_ROL  = 4'h6,
        OP_OR   = 4'h7,
        OP_AND  = 4'h8,
        OP_BIT  = 4'h9,
        OP_EOR  = 4'hA,
        OP_ONES = 4'hB,
        OP_LSR  = 4'hC
    } alu_op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] BCD_CORR = 4'd6;

    function automatic logic is_shift(input logic [3:0] op);
        return (op == OP_ROR) || (op == OP_ASL) || (op == OP_ROL) || (op == OP_LSR);
    endfunction

endpackage

// File: rtl/seq_alu_bcd_digit.sv
// bcd_digit: combinational single-digit decimal adder.
//   x, y  in  4  decimal digits (0-9 expected; other codes give a don't-care sum)
//   ci    in  1  carry in
//   s     out 4  corrected decimal sum digit
//   co    out 1  decimal carry out
// Subtraction is done by the caller feeding the 9's complement of the subtrahend.
module bcd_digit
    import alu_pkg::*;
(
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] raw;

    always_comb begin
        raw = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
        s   = raw[3:0];
        co  = 1'b0;
        if (raw > 5'd9) begin
            // Adding 6 skips the six unused codes; bit 4 of the sum is the decimal carry.
            s  = raw[3:0] + BCD_CORR;
            co = 1'b1;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU between the register file and the flag/result registers.
//   clk, resetb           clock, synchronous active-low reset
//   start, op, a, b,      request and operands; sampled only while busy=0
//   c_in, bcd, shamt
//   busy                  high while a multi-cycle operation is in RUN
//   done                  one-cycle pulse when y and the flags are updated
//   y, c_out, zero,       registered result and flags, held until the next done
//   negative, overflow
// Handshake: start is taken on any rising edge where busy=0 (including the cycle
// done=1); single-cycle ops raise done on that edge, BCD adc/sbc and shifts with
// shamt>0 raise busy on that edge and raise done on the edge busy falls.
// A start seen while busy=1 is dropped and the operands are not re-sampled.
module seq_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             bcd,
    input  logic [SHW-1:0]   shamt,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             c_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow
);

    localparam int DIGITS = WIDTH / 4;
    localparam int CW     = ($clog2(DIGITS + 1) > SHW) ? $clog2(DIGITS + 1) : SHW;

    state_t           state, state_nx;
    logic [CW-1:0]    cnt, cnt_nx;
    logic [WIDTH-1:0] wa, wa_nx, wb, wb_nx, wr, wr_nx;
    logic             cy, cy_nx;
    logic [3:0]       run_op, run_op_nx;

    logic             fin, fin_c, fin_v, fin_n;
    logic [WIDTH-1:0] fin_y;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_y, sh_y;
    logic             sc_c, sc_v, sh_c;
    logic             bcd_start, need_run;
    logic [3:0]       dig_y, dig_s;
    logic             dig_co;

    assign bcd_start = bcd && ((op == OP_ADC) || (op == OP_SBC));
    assign need_run  = bcd_start || (is_shift(op) && (shamt != '0));

    // Least significant digit of the working operands; sbc adds the 9's complement of a.
    assign dig_y = (run_op == OP_SBC) ? (4'd9 - wa[3:0]) : wa[3:0];

    bcd_digit u_digit (
        .x  (wb[3:0]),
        .y  (dig_y),
        .ci (cy),
        .s  (dig_s),
        .co (dig_co)
    );

    // Single-cycle result, also covers shifts with shamt=0.
    always_comb begin
        sum  = '0;
        sc_y = '0;
        sc_c = 1'b0;
        sc_v = 1'b0;
        case (op)
            OP_INC: begin
                sum  = {1'b0, a} + {{WIDTH{1'b0}}, c_in};
                sc_y = sum[WIDTH-1:0];
                sc_c = sum[WIDTH];
            end
            OP_DEC: begin
                // a + all-ones + ~c_in: carry out means no borrow.
                sum  = {1'b0, a} + {1'b0, {WIDTH{1'b1}}} + {{WIDTH{1'b0}}, ~c_in};
                sc_y = sum[WIDTH-1:0];
                sc_c = sum[WIDTH];
            end
            OP_ADC: begin
                sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, c_in};
                sc_y = sum[WIDTH-1:0];
                sc_c = sum[WIDTH];
                sc_v = (a[WIDTH-1] ^ b[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
            end
            OP_SBC: begin
                sum  = {1'b0, b} + {1'b0, ~a} + {{WIDTH{1'b0}}, c_in};
                sc_y = sum[WIDTH-1:0];
                sc_c = sum[WIDTH];
                sc_v = (b[WIDTH-1] ^ ~a[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
            end
            OP_ROR, OP_ASL, OP_ROL, OP_LSR: begin
                sc_y = a;
                sc_c = c_in;
            end
            OP_OR:  sc_y = a | b;
            OP_AND: sc_y = a & b;
            OP_BIT: begin
                sc_y = a & b;
                sc_v = a[WIDTH-2];
            end
            OP_EOR: sc_y = a ^ b;
            OP_ONES: begin
                sc_y = '1;
                sc_c = 1'b1;
                sc_v = 1'b1;
            end
            default: ;
        endcase
    end

    // One position of shift/rotate per RUN cycle; rotates go through the carry.
    always_comb begin
        sh_y = wr;
        sh_c = cy;
        case (run_op)
            OP_ROR: begin sh_y = {cy, wr[WIDTH-1:1]};   sh_c = wr[0];       end
            OP_ROL: begin sh_y = {wr[WIDTH-2:0], cy};   sh_c = wr[WIDTH-1]; end
            OP_ASL: begin sh_y = {wr[WIDTH-2:0], 1'b0}; sh_c = wr[WIDTH-1]; end
            OP_LSR: begin sh_y = {1'b0, wr[WIDTH-1:1]}; sh_c = wr[0];       end
            default: ;
        endcase
    end

    // Next-state and output-load logic.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        wa_nx     = wa;
        wb_nx     = wb;
        wr_nx     = wr;
        cy_nx     = cy;
        run_op_nx = run_op;
        fin       = 1'b0;
        fin_y     = '0;
        fin_c     = 1'b0;
        fin_v     = 1'b0;
        fin_n     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (need_run) begin
                        state_nx  = RUN;
                        cnt_nx    = bcd_start ? CW'(DIGITS) : CW'(shamt);
                        wa_nx     = a;
                        wb_nx     = b;
                        wr_nx     = bcd_start ? '0 : a;
                        cy_nx     = c_in;
                        run_op_nx = op;
                    end else begin
                        fin   = 1'b1;
                        fin_y = sc_y;
                        fin_c = sc_c;
                        fin_v = sc_v;
                        fin_n = sc_y[WIDTH-1] | ((op == OP_BIT) & a[WIDTH-1]);
                    end
                end
            end
            RUN: begin
                if ((run_op == OP_ADC) || (run_op == OP_SBC)) begin
                    // Digits enter at the top of wr so the result is aligned after the last one.
                    wa_nx = wa >> 4;
                    wb_nx = wb >> 4;
                    wr_nx = {dig_s, wr[WIDTH-1:4]};
                    cy_nx = dig_co;
                end else begin
                    wr_nx = sh_y;
                    cy_nx = sh_c;
                end
                // <= 1 rather than == 1 so a zero count can never strand the FSM.
                if (cnt <= CW'(1)) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    fin      = 1'b1;
                    fin_y    = wr_nx;
                    fin_c    = cy_nx;
                    fin_n    = wr_nx[WIDTH-1];
                end else begin
                    cnt_nx = cnt - CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state    <= IDLE;
            cnt      <= '0;
            wa       <= '0;
            wb       <= '0;
            wr       <= '0;
            cy       <= 1'b0;
            run_op   <= '0;
            done     <= 1'b0;
            y        <= '0;
            c_out    <= 1'b0;
            zero     <= 1'b0;
            negative <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            wa     <= wa_nx;
            wb     <= wb_nx;
            wr     <= wr_nx;
            cy     <= cy_nx;
            run_op <= run_op_nx;
            done   <= fin;
            if (fin) begin
                y        <= fin_y;
                c_out    <= fin_c;
                zero     <= (fin_y == '0);
                negative <= fin_n;
                overflow <= fin_v;
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu at WIDTH=8 and WIDTH=16.
module tb_seq_alu;

    logic clk = 1'b0;
    logic resetb = 1'b0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- WIDTH=8 instance ----------------
    logic       start8 = 1'b0;
    logic [3:0] op8 = '0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       ci8 = 1'b0, bcd8 = 1'b0;
    logic [2:0] sh8 = '0;
    logic       busy8, done8, c8, z8, n8, v8;
    logic [7:0] y8;

    seq_alu #(.WIDTH(8)) dut8 (
        .clk(clk), .resetb(resetb), .start(start8), .op(op8), .a(a8), .b(b8),
        .c_in(ci8), .bcd(bcd8), .shamt(sh8), .busy(busy8), .done(done8), .y(y8),
        .c_out(c8), .zero(z8), .negative(n8), .overflow(v8)
    );

    // ---------------- WIDTH=16 instance ----------------
    logic        start16 = 1'b0;
    logic [3:0]  op16 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        ci16 = 1'b0, bcd16 = 1'b0;
    logic [3:0]  sh16 = '0;
    logic        busy16, done16, c16, z16, n16, v16;
    logic [15:0] y16;

    seq_alu #(.WIDTH(16)) dut16 (
        .clk(clk), .resetb(resetb), .start(start16), .op(op16), .a(a16), .b(b16),
        .c_in(ci16), .bcd(bcd16), .shamt(sh16), .busy(busy16), .done(done16), .y(y16),
        .c_out(c16), .zero(z16), .negative(n16), .overflow(v16)
    );

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q8[$];   // {op, y, c, z, n, v}
    logic [19:0] exp_q16[$];  // {y, c, z, n, v}
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model, 8-bit: returns {y, c, z, n, v}.
    function automatic logic [11:0] model8(input logic [3:0] o, input logic [7:0] ra, input logic [7:0] rb,
                                           input logic ci, input logic bm, input logic [2:0] sh);
        int s, sv, da, db;
        logic [7:0] ry;
        logic c, v, n, nc;
        ry = '0; c = 1'b0; v = 1'b0;
        da = int'(ra[7:4]) * 10 + int'(ra[3:0]);
        db = int'(rb[7:4]) * 10 + int'(rb[3:0]);
        case (o)
            4'h0: begin s = int'(ra) + int'(ci); ry = s[7:0]; c = s[8]; end
            4'h1: begin ry = ra - {7'd0, ci}; c = (ra >= {7'd0, ci}); end
            4'h2: begin
                if (bm) begin
                    s = da + db + int'(ci);
                    c = (s >= 100);
                    s = s % 100;
                    ry = {4'(s / 10), 4'(s % 10)};
                end else begin
                    s = int'(ra) + int'(rb) + int'(ci);
                    ry = s[7:0]; c = s[8];
                    sv = int'($signed(ra)) + int'($signed(rb)) + int'(ci);
                    v = (sv > 127) || (sv < -128);
                end
            end
            4'h3: begin
                if (bm) begin
                    s = db - da - (1 - int'(ci));
                    c = (s >= 0);
                    if (s < 0) s = s + 100;
                    ry = {4'(s / 10), 4'(s % 10)};
                end else begin
                    s = int'(rb) + (255 - int'(ra)) + int'(ci);
                    ry = s[7:0]; c = s[8];
                    sv = int'($signed(rb)) - int'($signed(ra)) - (1 - int'(ci));
                    v = (sv > 127) || (sv < -128);
                end
            end
            4'h4, 4'h5, 4'h6, 4'hC: begin
                ry = ra; c = ci;
                for (int k = 0; k < int'(sh); k++) begin
                    case (o)
                        4'h4: begin nc = ry[0]; ry = {c, ry[7:1]}; end
                        4'h6: begin nc = ry[7]; ry = {ry[6:0], c}; end
                        4'h5: begin nc = ry[7]; ry = {ry[6:0], 1'b0}; end
                        default: begin nc = ry[0]; ry = {1'b0, ry[7:1]}; end
                    endcase
                    c = nc;
                end
            end
            4'h7: ry = ra | rb;
            4'h8: ry = ra & rb;
            4'h9: begin ry = ra & rb; v = ra[6]; end
            4'hA: ry = ra ^ rb;
            4'hB: begin ry = 8'hFF; c = 1'b1; v = 1'b1; end
            default: ;
        endcase
        n = ry[7] | ((o == 4'h9) & ra[7]);
        return {ry, c, (ry == 8'h00), n, v};
    endfunction

    // Monitors pop expected results whenever the DUTs signal done.
    always @(negedge clk) begin
        logic [15:0] e;
        if (resetb && done8) begin
            if (exp_q8.size() == 0) check("done8_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_q8.pop_front();
                check($sformatf("result8_op%h", e[15:12]), {20'd0, y8, c8, z8, n8, v8}, {20'd0, e[11:0]});
            end
        end
    end

    always @(negedge clk) begin
        logic [19:0] e;
        if (resetb && done16) begin
            if (exp_q16.size() == 0) check("done16_unexpected", 32'd1, 32'd0);
            else begin
                e = exp_q16.pop_front();
                check("result16", {12'd0, y16, c16, z16, n16, v16}, {12'd0, e});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive8(input logic [3:0] o, input logic [7:0] ra, input logic [7:0] rb,
                          input logic ci, input logic bm, input logic [2:0] sh, input bit push);
        op8 = o; a8 = ra; b8 = rb; ci8 = ci; bcd8 = bm; sh8 = sh; start8 = 1'b1;
        if (push) exp_q8.push_back({o, model8(o, ra, rb, ci, bm, sh)});
    endtask

    task automatic do_op8(input logic [3:0] o, input logic [7:0] ra, input logic [7:0] rb,
                          input logic ci, input logic bm, input logic [2:0] sh);
        int exp_lat, lat;
        bit seen;
        if (bm && (o == 4'h2 || o == 4'h3)) exp_lat = 3;
        else if ((o == 4'h4 || o == 4'h5 || o == 4'h6 || o == 4'hC) && sh != 3'd0) exp_lat = int'(sh) + 1;
        else exp_lat = 1;
        @(negedge clk);
        drive8(o, ra, rb, ci, bm, sh, 1'b1);
        seen = 1'b0;
        lat = 99;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            start8 = 1'b0;
            if (i == 1 && exp_lat > 1) check("busy_in_run", {31'd0, busy8}, 32'd1);
            if (done8) begin seen = 1'b1; lat = i; end
        end
        check($sformatf("latency_op%h", o), lat, exp_lat);
        check("busy_at_done", {31'd0, busy8}, 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        bit seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy8}, 32'd0);
        check("rst_done", {31'd0, done8}, 32'd0);
        check("rst_y", {24'd0, y8}, 32'd0);
        check("rst_flags", {28'd0, c8, z8, n8, v8}, 32'd0);
        check("rst_y16", {16'd0, y16}, 32'd0);
        resetb = 1'b1;

        // Directed cases
        do_op8(4'h2, 8'h45, 8'h38, 1'b0, 1'b1, 3'd0);  // BCD adc -> 0x83
        do_op8(4'h2, 8'h99, 8'h01, 1'b0, 1'b1, 3'd0);  // BCD adc wrap -> 0x00, c=1
        do_op8(4'h3, 8'h21, 8'h50, 1'b1, 1'b1, 3'd0);  // BCD sbc -> 0x29
        do_op8(4'h3, 8'h50, 8'h21, 1'b1, 1'b1, 3'd0);  // BCD sbc with borrow
        do_op8(4'h2, 8'h7F, 8'h01, 1'b0, 1'b0, 3'd0);  // signed overflow
        do_op8(4'h3, 8'h01, 8'h80, 1'b1, 1'b0, 3'd0);  // sbc overflow
        do_op8(4'h5, 8'h81, 8'h00, 1'b0, 1'b0, 3'd3);  // asl 3
        do_op8(4'h6, 8'h80, 8'h00, 1'b1, 1'b0, 3'd1);  // rol through carry
        do_op8(4'h4, 8'h01, 8'h00, 1'b0, 1'b0, 3'd7);  // ror 7
        do_op8(4'hC, 8'hF0, 8'h00, 1'b1, 1'b0, 3'd0);  // lsr shamt=0
        do_op8(4'h0, 8'hFF, 8'h00, 1'b1, 1'b0, 3'd0);  // inc wrap
        do_op8(4'h1, 8'h00, 8'h00, 1'b1, 1'b0, 3'd0);  // dec wrap
        do_op8(4'h9, 8'hC0, 8'h0F, 1'b0, 1'b0, 3'd0);  // bit: zero but negative, overflow
        do_op8(4'hB, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0);  // ones
        do_op8(4'hE, 8'hAA, 8'h55, 1'b1, 1'b0, 3'd0);  // undefined opcode

        // Back-to-back single-cycle ops, including start in the done cycle
        @(negedge clk); drive8(4'h7, 8'h0F, 8'hF0, 1'b0, 1'b0, 3'd0, 1'b1);
        @(negedge clk); drive8(4'hA, 8'h3C, 8'h3C, 1'b0, 1'b0, 3'd0, 1'b1);
        @(negedge clk); drive8(4'h8, 8'hAA, 8'h0F, 1'b0, 1'b0, 3'd0, 1'b1);
        @(negedge clk); drive8(4'h0, 8'h41, 8'h00, 1'b1, 1'b0, 3'd0, 1'b1);
        @(negedge clk); start8 = 1'b0;
        repeat (2) @(negedge clk);

        // Start during RUN is ignored
        @(negedge clk); drive8(4'h2, 8'h12, 8'h34, 1'b0, 1'b1, 3'd0, 1'b1);
        @(negedge clk);
        check("ign_busy", {31'd0, busy8}, 32'd1);
        drive8(4'hB, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk); start8 = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during the second RUN cycle discards the operation
        @(negedge clk); drive8(4'h2, 8'h11, 8'h22, 1'b0, 1'b1, 3'd0, 1'b0);
        @(negedge clk); start8 = 1'b0;
        @(negedge clk);
        check("pre_rst_busy", {31'd0, busy8}, 32'd1);
        resetb = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy8}, 32'd0);
        check("midrst_done", {31'd0, done8}, 32'd0);
        check("midrst_y", {24'd0, y8}, 32'd0);
        check("midrst_flags", {28'd0, c8, z8, n8, v8}, 32'd0);
        resetb = 1'b1;
        repeat (2) @(negedge clk);

        // WIDTH=16 BCD adc 9999 + 0001
        @(negedge clk);
        op16 = 4'h2; a16 = 16'h9999; b16 = 16'h0001; ci16 = 1'b0; bcd16 = 1'b1; start16 = 1'b1;
        exp_q16.push_back({16'h0000, 1'b1, 1'b1, 1'b0, 1'b0});
        seen = 1'b0;
        lat = 99;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            start16 = 1'b0;
            if (i == 1) check("busy16_run", {31'd0, busy16}, 32'd1);
            if (done16) begin seen = 1'b1; lat = i; end
        end
        check("latency16", lat, 5);

        // Random operations through the model
        for (int i = 0; i < 40; i++) begin
            logic [3:0] o;
            logic [7:0] ra, rb;
            logic bm;
            o  = 4'($urandom_range(0, 15));
            bm = 1'($urandom_range(0, 1));
            if (bm && (o == 4'h2 || o == 4'h3)) begin
                ra = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                rb = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end else begin
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
            end
            do_op8(o, ra, rb, 1'($urandom_range(0, 1)), bm, 3'($urandom_range(0, 7)));
        end

        repeat (3) @(negedge clk);
        check("q8_empty", exp_q8.size(), 32'd0);
        check("q16_empty", exp_q16.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, multi-cycle successor to the CPU datapath ALU. Executes the existing 4-bit opcode set on a WIDTH-bit datapath. Adds nibble-serial decimal (BCD) add/subtract, multi-position shifts/rotates and true signed overflow. Sits between the register file and the flag/result registers and uses a start/busy/done handshake so the control FSM can stall on multi-cycle operations.

## Interface
- WIDTH, 8, datapath width; a multiple of 4, at least 8
- SHW, $clog2(WIDTH), shift-amount width
- clk  in  1  single clock, all state on the rising edge
- resetb  in  1  synchronous, active-low reset
- start  in  1  request; accepted only while busy=0
- op  in  4  opcode, sampled with start
- a, b  in  WIDTH  operands, sampled with start
- c_in  in  1  carry/borrow-in, sampled with start
- bcd  in  1  decimal mode for adc/sbc, sampled with start
- shamt  in  SHW  shift count for ror/asl/rol/lsr, sampled with start
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when y and the flags update
- y  out  WIDTH  result, held until the next done
- c_out, zero, negative, overflow  out  1 each  flags, held with y

## Operation
- Opcodes: 0 inc (a+c_in), 1 dec (a−c_in), 2 adc (a+b+c_in), 3 sbc (b+~a+c_in), 4 ror, 5 asl, 6 rol, 7 or, 8 and, 9 bit, a eor, b ones, c lsr, d–f → y=0, c_out=0.
- Binary adc/sbc: overflow = carry into MSB XOR carry out of MSB. Other ops: overflow=0, except bit (a[WIDTH−2]) and ones (1).
- zero = (y==0). negative = y[WIDTH−1], ORed with a[WIDTH−1] for bit.
- bit: y = a&b, c_out=0. ones: y = all ones, c_out=1.
- BCD (bcd=1, op 2/3): one nibble per cycle, LSB digit first, through bcd_digit.
  - adc digit: s = a_d+b_d+cy; if s>9 then s+=6 and cy=1.
  - sbc computes b−a−(1−c_in) decimally; c_out=1 means no borrow.
  - overflow=0. Digits outside 0–9 give an unspecified y; the FSM must not hang.
- Shifts move one position per cycle, shamt positions in total.
  - ror/rol rotate through carry. asl/lsr fill with 0.
  - c_out = last bit shifted out.
  - shamt=0: y=a, c_out=c_in.
- FSM states:
  - IDLE: a start with a single-cycle op (or shamt=0) loads the outputs directly. A start with BCD or shamt>0 → RUN with counter = WIDTH/4 or shamt.
  - RUN: busy=1, decrement the counter each cycle. At zero → IDLE, load outputs, done=1.
- start while busy=1 is ignored; operands are not re-sampled.
- Reset (any state, including mid-RUN) → IDLE. busy=0, done=0, y=0, all flags 0. Partial results are discarded.

## Timing
- Single-cycle ops: done and the new y/flags appear on the edge after start (latency 1). busy stays 0.
- BCD: busy=1 from the edge after start for WIDTH/4 cycles. done coincides with busy falling. Latency WIDTH/4 + 1.
- Shift with shamt>0: latency shamt + 1.
- start is allowed in the same cycle done=1; back-to-back single-cycle ops run at one per cycle.
- Outputs are registered; no combinational path from the inputs to the outputs.

## Structure
- alu_pkg: alu_op_t enum (the 4-bit codes above), state_t {IDLE, RUN}, BCD_CORR constant = 6.
- Sub-module bcd_digit: combinational 4-bit decimal add with correction. Inputs x, y, ci; outputs s, co. sbc feeds the 9's complement of a_d.
- Counter width is max($clog2(WIDTH/4+1), SHW).

## Test plan
- WIDTH=8, adc, bcd=1, a=0x45, b=0x38, c_in=0 → y=0x83, c_out=0, busy for 2 cycles, done at cycle 3.
- WIDTH=8, BCD adc 0x99+0x01, c_in=0 → y=0x00, c_out=1, zero=1. BCD sbc b=0x50, a=0x21, c_in=1 → y=0x29, c_out=1.
- WIDTH=8, binary adc 0x7F+0x01, c_in=0 → y=0x80, overflow=1, negative=1, done 1 cycle after start, busy never set.
- WIDTH=8, asl, a=0x81, shamt=3 → y=0x08, c_out=0 after 4 cycles. rol, a=0x80, c_in=1, shamt=1 → y=0x01, c_out=1.
- Reset asserted during the second cycle of RUN → next cycle busy=0, done=0, y=0, flags 0. A start during RUN is ignored and the original result completes.
- WIDTH=16, BCD adc 0x9999+0x0001 → y=0x0000, c_out=1, zero=1, done 5 cycles after start.
